// File: rtl/stream_pkg.sv
// Shared stream-arbitration types and the rotate-priority search used by the team's arbiters.
package stream_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  // First set bit of req strictly after last, wrapping modulo nch; returns last when req is empty.
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last,
                                         input int unsigned nch);
    logic       found;
    logic [3:0] idx;
    rr_next = last;
    found   = 1'b0;
    for (int unsigned i = 1; i <= 16; i++) begin
      idx = 4'((32'(last) + i) % nch);
      if (!found && (i <= nch) && req[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder, search starts just above i_last and wraps.
module rr_pick
  import stream_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_last,
  output logic [IW-1:0]  o_sel,
  output logic           o_any
);

  logic [15:0] w_req;

  always_comb begin
    w_req          = '0;
    w_req[NCH-1:0] = i_req;
    o_sel          = IW'(rr_next(w_req, 4'(i_last), NCH));
    o_any          = |i_req;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter: NCH requesters share one registered output; a grant lasts one packet or BURST beats.
// Define STREAM_RR_ARBITER_ID_EN to add the registered otid source-channel output.
module stream_rr_arbiter
  import stream_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned BURST = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NCH-1:0]         itvalid,
  output logic [NCH-1:0]         itready,
  input  logic [NCH*DSIZE-1:0]   itdata,
  input  logic [NCH-1:0]         itlast,
  output logic                   otvalid,
  input  logic                   otready,
  output logic [DSIZE-1:0]       otdata,
  output logic                   otlast
`ifdef STREAM_RR_ARBITER_ID_EN
  ,
  output logic [$clog2(NCH)-1:0] otid
`endif
);

  localparam int unsigned IW = $clog2(NCH);
  localparam int unsigned CW = $clog2(BURST + 1);

  arb_state_t       r_state;
  logic [IW-1:0]    r_gsel;
  logic [IW-1:0]    r_last;
  logic [CW-1:0]    r_cnt;
  logic             r_otvalid;
  logic             r_otlast;
  logic [DSIZE-1:0] r_otdata;

  logic [IW-1:0]    w_sel;
  logic             w_any;
  logic             w_rdy;
  logic             w_acc;
  logic             w_end;
  logic [DSIZE-1:0] w_beat;

  rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .i_req  (itvalid),
    .i_last (r_last),
    .o_sel  (w_sel),
    .o_any  (w_any)
  );

  // itready depends only on state and otready, never on itvalid/itdata.
  always_comb begin
    w_rdy   = ~r_otvalid | otready;
    w_beat  = itdata[r_gsel*DSIZE +: DSIZE];
    w_acc   = (r_state == GRANT) & itvalid[r_gsel] & w_rdy;
    w_end   = itlast[r_gsel] | (r_cnt == CW'(BURST - 1));
    itready = '0;
    if (r_state == GRANT) itready[r_gsel] = w_rdy;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_gsel    <= '0;
      r_last    <= IW'(NCH - 1);
      r_cnt     <= '0;
      r_otvalid <= 1'b0;
      r_otdata  <= '0;
      r_otlast  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_otvalid <= 1'b1;
        r_otdata  <= w_beat;
        r_otlast  <= w_end;
        r_cnt     <= r_cnt + CW'(1);
      end else if (otready) begin
        r_otvalid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_gsel  <= w_sel;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_acc && w_end) begin
            r_state <= IDLE;
            r_last  <= r_gsel;
          end
        end
      endcase
    end
  end

`ifdef STREAM_RR_ARBITER_ID_EN
  logic [IW-1:0] r_otid;

  always_ff @(posedge clk) begin
    if (!rstn)      r_otid <= '0;
    else if (w_acc) r_otid <= r_gsel;
  end

  assign otid = r_otid;
`endif

  assign otvalid = r_otvalid;
  assign otdata  = r_otdata;
  assign otlast  = r_otlast;

endmodule
